// File: rtl/mtc_rx_unpacker_pkg.sv
// Shared MTC2SL bus field constants and the MTC procflag codes used by the unpacker.
package l0mdt_buses_constants;
  localparam int MTC2SL_LEN                = 32;
  localparam int MTC2SL_MDT_PROCFLAGS_MSB  = 7;
  localparam int MTC2SL_MDT_PROCFLAGS_LSB  = 4;
endpackage

package mtc_rx_unpacker_pkg;
  typedef enum logic [3:0] {
    PROC_BUSY = 4'd0,
    PROC_PASS = 4'd1,
    PROC_FAIL = 4'd2
  } procflag_t;
endpackage

// File: rtl/mtc_rx_mwfifo.sv
// Multi-write / single-read first-word-fall-through packet buffer.
module mtc_rx_mwfifo #(
  parameter int N_WR  = 3,
  parameter int DEPTH = 8,
  parameter int WIDTH = 31,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int NW   = $clog2(N_WR + 1)
)(
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [N_WR*WIDTH-1:0]   wr_data,
  input  logic [NW-1:0]           wr_num,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic [CW-1:0]           count
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [CW-1:0]    count_reg;

  // wr_data is already compacted: entry k lands at wptr+k for the first wr_num entries
  always_ff @(posedge clock) begin
    if (rst_n) begin
      for (int k = 0; k < N_WR; k++) begin
        if (NW'(k) < wr_num)
          mem_reg[wptr_reg + AW'(k)] <= wr_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_reg + AW'(wr_num);
      rptr_reg  <= rptr_reg + AW'(rd_en);
      count_reg <= count_reg + CW'(wr_num) - CW'(rd_en);
    end
  end

  assign count   = count_reg;
  assign rd_data = (count_reg != '0) ? mem_reg[rptr_reg] : '0;
endmodule

// File: rtl/mtc_rx_unpacker.sv
// Unpacks N_MTC parallel MTC2SL lanes into one FWFT packet stream with drop and procflag statistics.
module mtc_rx_unpacker
  import l0mdt_buses_constants::*;
  import mtc_rx_unpacker_pkg::*;
#(
  parameter int N_MTC      = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
)(
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic                          srst,
  input  logic [MTC2SL_LEN*N_MTC-1:0]   mtc,
  output logic [MTC2SL_LEN-2:0]         out_data,
  output logic [3:0]                    out_procflags,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          fifo_full,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [CNT_WIDTH-1:0]          pass_cnt,
  output logic [CNT_WIDTH-1:0]          fail_cnt,
  output logic [CNT_WIDTH-1:0]          busy_cnt
);
  localparam int PW = MTC2SL_LEN - 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(N_MTC + 1);

  logic                 rst_n_int;
  logic                 pop;
  logic [CW-1:0]        count;
  logic [CW-1:0]        free;
  logic [N_MTC-1:0]     lane_valid;
  logic [PW-1:0]        lane_data   [N_MTC];
  logic [PW-1:0]        packed_data [N_MTC];
  logic [N_MTC*PW-1:0]  wr_data_flat;
  logic [LW-1:0]        wr_num;
  logic [LW-1:0]        drop_num;
  logic [CNT_WIDTH-1:0] drop_cnt_reg, pass_cnt_reg, fail_cnt_reg, busy_cnt_reg;

  assign rst_n_int = rst_n & ~srst;

  generate
    for (genvar gi = 0; gi < N_MTC; gi++) begin : g_lane
      assign lane_valid[gi] = mtc[gi*MTC2SL_LEN + MTC2SL_LEN - 1];
      assign lane_data[gi]  = mtc[gi*MTC2SL_LEN +: PW];
      assign wr_data_flat[gi*PW +: PW] = packed_data[gi];
    end
  endgenerate

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  // The slot freed by this cycle's pop is writable in the same cycle
  assign free      = CW'(FIFO_DEPTH) - count + CW'(pop);

  always_comb begin
    wr_num   = '0;
    drop_num = '0;
    for (int i = 0; i < N_MTC; i++) packed_data[i] = '0;
    for (int i = 0; i < N_MTC; i++) begin
      if (lane_valid[i]) begin
        if (int'(wr_num) < int'(free)) begin
          for (int j = 0; j < N_MTC; j++)
            if (int'(wr_num) == j) packed_data[j] = lane_data[i];
          wr_num = wr_num + LW'(1);
        end else begin
          drop_num = drop_num + LW'(1);
        end
      end
    end
  end

  mtc_rx_mwfifo #(
    .N_WR  (N_MTC),
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n_int),
    .wr_data (wr_data_flat),
    .wr_num  (wr_num),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (count)
  );

  assign out_procflags = out_data[MTC2SL_MDT_PROCFLAGS_MSB:MTC2SL_MDT_PROCFLAGS_LSB];

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [LW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(b);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clock) begin
    if (!rst_n_int) begin
      drop_cnt_reg <= '0;
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
      busy_cnt_reg <= '0;
    end else begin
      drop_cnt_reg <= sat_add(drop_cnt_reg, drop_num);
      if (pop) begin
        if (out_procflags == PROC_PASS) pass_cnt_reg <= sat_add(pass_cnt_reg, LW'(1));
        if (out_procflags == PROC_FAIL) fail_cnt_reg <= sat_add(fail_cnt_reg, LW'(1));
        if (out_procflags == PROC_BUSY) busy_cnt_reg <= sat_add(busy_cnt_reg, LW'(1));
      end
    end
  end

  assign drop_cnt = drop_cnt_reg;
  assign pass_cnt = pass_cnt_reg;
  assign fail_cnt = fail_cnt_reg;
  assign busy_cnt = busy_cnt_reg;
endmodule

// File: tb/tb_mtc_rx_unpacker.sv
// Scoreboard bench for mtc_rx_unpacker: expected packets queued on drive, compared on pop.
module tb_mtc_rx_unpacker;
  import l0mdt_buses_constants::*;

  localparam int N_MTC = 3;
  localparam int DEPTH = 8;
  localparam int LEN   = MTC2SL_LEN;

  logic                  clock = 1'b0;
  logic                  rst_n;
  logic                  srst;
  logic [LEN*N_MTC-1:0]  mtc;
  logic [LEN-2:0]        out_data;
  logic [3:0]            out_procflags;
  logic                  out_valid;
  logic                  out_ready;
  logic                  fifo_full;
  logic [15:0]           drop_cnt, pass_cnt, fail_cnt, busy_cnt;

  mtc_rx_unpacker #(.N_MTC(N_MTC), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
    .clock(clock), .rst_n(rst_n), .srst(srst), .mtc(mtc),
    .out_data(out_data), .out_procflags(out_procflags), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full),
    .drop_cnt(drop_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy_cnt(busy_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [LEN-2:0] sb[$];
  int exp_drop = 0, exp_pass = 0, exp_fail = 0, exp_busy = 0;
  int tag = 1;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [LEN-1:0] mk(input logic v, input int t, input int flags);
    return {v, 23'(t), 4'(flags), 4'h0};
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // n lowest lanes valid, the rest idle
  function automatic logic [LEN*N_MTC-1:0] lanes_n(input int n, input int t);
    logic [LEN*N_MTC-1:0] m;
    m = '0;
    for (int i = 0; i < N_MTC; i++)
      if (i < n) m[i*LEN +: LEN] = mk(1'b1, t + i, (t + i) % 4);
    return m;
  endfunction

  // Apply one cycle of stimulus; check outputs before and after the edge
  task automatic step(input logic [LEN*N_MTC-1:0] m, input logic rdy,
                      input logic rn = 1'b1, input logic sr = 1'b0);
    logic [LEN-2:0] p;
    int fl;
    mtc = m; out_ready = rdy; rst_n = rn; srst = sr;
    #1;
    check_val("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check_val("fifo_full", 64'(fifo_full), 64'(sb.size() == DEPTH));
    if (sb.size() != 0) begin
      check_val("out_data", 64'(out_data), 64'(sb[0]));
      check_val("out_procflags", 64'(out_procflags), 64'(sb[0][7:4]));
    end
    if (!rn || sr) begin
      sb.delete();
      exp_drop = 0; exp_pass = 0; exp_fail = 0; exp_busy = 0;
    end else begin
      if (sb.size() != 0 && rdy) begin
        p = sb.pop_front();
        fl = int'(p[7:4]);
        $display("pop data=%h flags=%0d", p, fl);
        if (fl == 1) exp_pass = sat(exp_pass + 1);
        if (fl == 2) exp_fail = sat(exp_fail + 1);
        if (fl == 0) exp_busy = sat(exp_busy + 1);
      end
      for (int i = 0; i < N_MTC; i++) begin
        if (m[i*LEN + LEN - 1]) begin
          if (sb.size() < DEPTH) sb.push_back(m[i*LEN +: LEN-1]);
          else exp_drop = sat(exp_drop + 1);
        end
      end
    end
    @(posedge clock);
    #1;
    check_val("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check_val("pass_cnt", 64'(pass_cnt), 64'(exp_pass));
    check_val("fail_cnt", 64'(fail_cnt), 64'(exp_fail));
    check_val("busy_cnt", 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    int guard;
    int remain;
    logic [LEN*N_MTC-1:0] m;

    rst_n = 1'b0; srst = 1'b0; out_ready = 1'b0; mtc = '0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_fifo_full", 64'(fifo_full), 64'd0);
    check_val("rst_out_data", 64'(out_data), 64'd0);
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // lanes {valid, invalid, valid}: A on lane 0, C on lane 2
    step({mk(1'b1, 12, 3), mk(1'b0, 11, 1), mk(1'b1, 10, 3)}, 1'b1);
    check_val("ac_valid", 64'(out_valid), 64'd1);
    check_val("ac_first", 64'(out_data[30:8]), 64'd10);
    step('0, 1'b1);
    check_val("ac_second", 64'(out_data[30:8]), 64'd12);
    step('0, 1'b1);
    check_val("ac_empty", 64'(out_valid), 64'd0);
    check_val("ac_drop", 64'(drop_cnt), 64'd0);

    // three cycles of three lanes, no drain: third cycle takes lanes 0-1 only
    for (int c = 0; c < 3; c++) begin
      step(lanes_n(3, tag), 1'b0);
      tag += 3;
    end
    check_val("fill_full", 64'(fifo_full), 64'd1);
    check_val("fill_drop", 64'(drop_cnt), 64'd1);

    // full buffer, pop and push together
    step(lanes_n(1, tag), 1'b1);
    tag += 3;
    check_val("pp_full", 64'(fifo_full), 64'd1);
    check_val("pp_drop", 64'(drop_cnt), 64'd1);

    repeat (9) step('0, 1'b1);

    for (int c = 0; c < 60; c++) begin
      m = '0;
      for (int i = 0; i < N_MTC; i++)
        m[i*LEN +: LEN] = mk(1'($urandom_range(0, 1)), tag + i, int'($urandom_range(0, 3)));
      tag += 3;
      step(m, 1'($urandom_range(0, 1)));
    end

    // soft clear, then procflags 1,2,0,3 popped in order
    step(lanes_n(3, tag), 1'b1, 1'b1, 1'b1);
    check_val("srst_valid", 64'(out_valid), 64'd0);
    step({mk(1'b0, 0, 0), mk(1'b1, 201, 2), mk(1'b1, 200, 1)}, 1'b0);
    step({mk(1'b0, 0, 0), mk(1'b1, 203, 3), mk(1'b1, 202, 0)}, 1'b0);
    repeat (5) step('0, 1'b1);
    check_val("stat_pass", 64'(pass_cnt), 64'd1);
    check_val("stat_fail", 64'(fail_cnt), 64'd1);
    check_val("stat_busy", 64'(busy_cnt), 64'd1);

    // reset with five buffered packets plus same-cycle inputs
    step(lanes_n(3, tag), 1'b0); tag += 3;
    step(lanes_n(2, tag), 1'b0); tag += 3;
    step(lanes_n(3, tag), 1'b0, 1'b0, 1'b0); tag += 3;
    check_val("rstmid_valid", 64'(out_valid), 64'd0);
    check_val("rstmid_pass", 64'(pass_cnt), 64'd0);
    check_val("rstmid_drop", 64'(drop_cnt), 64'd0);
    step(lanes_n(1, 300), 1'b0);
    check_val("rstmid_accept", 64'(out_valid), 64'd1);
    step('0, 1'b1);

    // drive drop_cnt to 0xFFFE, then saturate
    guard = 0;
    while (exp_drop <= 65531 && guard < 30000) begin
      step(lanes_n(3, tag), 1'b0);
      guard++;
    end
    check_val("sat_bound", 64'(guard < 30000), 64'd1);
    remain = 65534 - exp_drop;
    step(lanes_n(remain, tag), 1'b0);
    check_val("sat_fffe", 64'(drop_cnt), 64'hFFFE);
    step(lanes_n(3, tag), 1'b0);
    check_val("sat_ffff", 64'(drop_cnt), 64'hFFFF);
    step(lanes_n(3, tag), 1'b0);
    check_val("sat_hold", 64'(drop_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
